// File: rtl/bky_pkg.sv
// Shared types and constants for the Buckeye shift-chain configuration sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package bky_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } bky_state_t;

   localparam int BKY_BITS_PER_AMP = 48;
   localparam int BKY_NAMP         = 6;
   localparam int BKY_MAX_WORDS    = 18;

   // Number of amplifiers selected by a 6-bit mask.
   function automatic logic [2:0] popcount6(input logic [5:0] m);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < 6; i++) begin
         c = c + {2'b00, m[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/bky_bit_timer.sv
// Bit-period timer: phase counter p = 0..2*CLKDIV-1 and the generated shift clock.
// Latency: SH_CLK is registered; it is high for p >= CLKDIV, low whenever i_run drops.
// Backpressure: none; the counter free-runs while i_run is high and parks at p = 0 otherwise.
// Ports: CLK/RST clock and async reset; i_run enables counting;
//        o_sh_clk shift clock; o_tx_strobe (p = 0), o_sample_strobe (p = CLKDIV-1),
//        o_bit_end (p = 2*CLKDIV-1) single-cycle phase markers.
module bky_bit_timer #(
   parameter int CLKDIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_run,
   output logic o_sh_clk,
   output logic o_tx_strobe,
   output logic o_sample_strobe,
   output logic o_bit_end
);

   localparam logic [4:0] P_LAST = 5'(2 * CLKDIV - 1);
   localparam logic [4:0] P_SAMP = 5'(CLKDIV - 1);
   localparam logic [4:0] P_HIGH = 5'(CLKDIV);

   logic [4:0] r_p;
   logic       r_clk;
   logic [4:0] w_p_next;

   assign w_p_next = (r_p == P_LAST) ? 5'd0 : r_p + 5'd1;

   // The clock register looks one phase ahead so SH_CLK is high exactly when p >= CLKDIV.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_p   <= 5'd0;
         r_clk <= 1'b0;
      end else if (!i_run) begin
         r_p   <= 5'd0;
         r_clk <= 1'b0;
      end else begin
         r_p   <= w_p_next;
         r_clk <= (w_p_next >= P_HIGH);
      end
   end

   assign o_sh_clk        = r_clk;
   assign o_tx_strobe     = i_run && (r_p == 5'd0);
   assign o_sample_strobe = i_run && (r_p == P_SAMP);
   assign o_bit_end       = i_run && (r_p == P_LAST);

endmodule

// File: rtl/bky_cfg_seq.sv
// Autonomous loader for the Buckeye amplifier shift chain from a 16-bit pattern RAM, with optional verify pass.
// Latency: DONE at START + 1 + passes*NW*(2 + 32*CLKDIV) cycles; BUSY rises the cycle after START.
// Backpressure: none; START is ignored while busy, ABORT returns to IDLE on the next cycle.
// Ports: CLK/RST; START/ABORT/MASK/VERIFY control; BUSY/DONE/ERR/ERR_CNT status;
//        RD_EN/RD_ADDR/RD_DATA pattern RAM (1-cycle read); SH_* shift-engine drive, SH_TDO chain return;
//        MASK_OUT latched amplifier select.
module bky_cfg_seq
   import bky_pkg::*;
#(
   parameter int CLKDIV       = 4,
   parameter int BITS_PER_AMP = BKY_BITS_PER_AMP
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic        ABORT,
   input  logic [5:0]  MASK,
   input  logic        VERIFY,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [8:0]  ERR_CNT,
   output logic        RD_EN,
   output logic [4:0]  RD_ADDR,
   input  logic [15:0] RD_DATA,
   output logic        SH_SEL,
   output logic        SH_F,
   output logic        SH_SHIFT,
   output logic        SH_CLK,
   output logic        SH_TDI,
   input  logic        SH_TDO,
   output logic [5:0]  MASK_OUT
);

   bky_state_t  r_state;
   logic        r_ld_ph;      // 0: read strobe cycle, 1: capture cycle
   logic        r_pass2;
   logic        r_verify;
   logic [4:0]  r_nw;
   logic [4:0]  r_word;
   logic [3:0]  r_bit;
   logic [15:0] r_buf;        // bit 0 is always the bit of the current period
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [8:0]  r_err_cnt;
   logic        r_rd_en;
   logic [4:0]  r_rd_addr;
   logic        r_shift;
   logic        r_tdi;
   logic [5:0]  r_mask;

   logic [2:0]  w_n;
   logic [4:0]  w_nw;
   logic        w_run;
   logic        w_tx;
   logic        w_sample;
   logic        w_bit_end;

   assign w_n  = (MASK == 6'd0) ? 3'(BKY_NAMP) : popcount6(MASK);
   assign w_nw = 5'((BITS_PER_AMP * int'(w_n)) / 16);

   // Gating with ABORT makes SH_CLK low on the very next cycle.
   assign w_run = (r_state == SHIFT) && !ABORT;

   bky_bit_timer #(.CLKDIV(CLKDIV)) u_timer (
      .CLK             (CLK),
      .RST             (RST),
      .i_run           (w_run),
      .o_sh_clk        (SH_CLK),
      .o_tx_strobe     (w_tx),
      .o_sample_strobe (w_sample),
      .o_bit_end       (w_bit_end)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= IDLE;
         r_ld_ph   <= 1'b0;
         r_pass2   <= 1'b0;
         r_verify  <= 1'b0;
         r_nw      <= 5'd0;
         r_word    <= 5'd0;
         r_bit     <= 4'd0;
         r_buf     <= 16'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= 9'd0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= 5'd0;
         r_shift   <= 1'b0;
         r_tdi     <= 1'b0;
         r_mask    <= 6'd0;
      end else begin
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         if (ABORT && r_busy) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_shift <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (START && !ABORT) begin
                     r_mask    <= MASK;
                     r_verify  <= VERIFY;
                     r_err     <= 1'b0;
                     r_err_cnt <= 9'd0;
                     r_nw      <= w_nw;
                     r_word    <= 5'd0;
                     r_pass2   <= 1'b0;
                     r_busy    <= 1'b1;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= 5'd0;
                     r_ld_ph   <= 1'b0;
                     r_state   <= LOAD;
                  end
               end
               LOAD: begin
                  if (!r_ld_ph) begin
                     r_ld_ph <= 1'b1;
                  end else begin
                     r_buf   <= RD_DATA;
                     r_bit   <= 4'd0;
                     r_shift <= 1'b1;
                     r_state <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (w_tx) begin
                     r_tdi <= r_buf[0];
                  end
                  // The chain is an NB-bit FIFO, so in pass 2 the returned bit matches the one being sent.
                  if (w_sample && r_pass2 && (SH_TDO != r_buf[0])) begin
                     r_err <= 1'b1;
                     if (r_err_cnt != 9'h1FF) begin
                        r_err_cnt <= r_err_cnt + 9'd1;
                     end
                  end
                  if (w_bit_end) begin
                     if (r_bit != 4'd15) begin
                        r_bit <= r_bit + 4'd1;
                        r_buf <= {1'b0, r_buf[15:1]};
                     end else begin
                        r_shift <= 1'b0;
                        r_ld_ph <= 1'b0;
                        if (r_word != r_nw - 5'd1) begin
                           r_word    <= r_word + 5'd1;
                           r_rd_addr <= r_word + 5'd1;
                           r_rd_en   <= 1'b1;
                           r_state   <= LOAD;
                        end else if (r_verify && !r_pass2) begin
                           r_pass2   <= 1'b1;
                           r_word    <= 5'd0;
                           r_rd_addr <= 5'd0;
                           r_rd_en   <= 1'b1;
                           r_state   <= LOAD;
                        end else begin
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_state <= IDLE;
                        end
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign BUSY     = r_busy;
   assign DONE     = r_done;
   assign ERR      = r_err;
   assign ERR_CNT  = r_err_cnt;
   assign RD_EN    = r_rd_en;
   assign RD_ADDR  = r_rd_addr;
   assign SH_SEL   = r_busy;
   assign SH_F     = r_busy;
   assign SH_SHIFT = r_shift;
   assign SH_TDI   = r_tdi;
   assign MASK_OUT = r_mask;

endmodule

// File: tb/tb_bky_cfg_seq.sv
// Scoreboard bench for bky_cfg_seq: a reference model fills expected queues per sequence,
// a negedge monitor pops and compares reads, shifted bits and DONE; a loop-back chain model drives SH_TDO.
module tb_bky_cfg_seq;

   localparam int CLKDIV = 4;

   logic        CLK = 1'b0;
   logic        RST, START, ABORT, VERIFY;
   logic [5:0]  MASK;
   logic        BUSY, DONE, ERR, RD_EN, SH_SEL, SH_F, SH_SHIFT, SH_CLK, SH_TDI, SH_TDO;
   logic [8:0]  ERR_CNT;
   logic [4:0]  RD_ADDR;
   logic [15:0] RD_DATA;
   logic [5:0]  MASK_OUT;

   typedef struct {
      int   cyc;
      int   err;
      int   cnt;
      int   edges;
   } rec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          inv_bad = 0;
   int          edge_cnt = 0;
   int          cur_nb = 48;
   int          chain_len = 48;
   logic        cur_verify = 1'b0;
   logic [5:0]  exp_mask = 6'd0;
   logic        prev_clk = 1'b0;
   logic        tdo_drv = 1'b0;
   logic [287:0] chain = '0;
   logic        fault_map [288];
   logic [15:0] mem [18];
   int          addr_q [$];
   logic        bit_q [$];
   rec_t        done_q [$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) begin
      if (RD_EN && RD_ADDR < 5'd18) RD_DATA <= mem[RD_ADDR];
   end

   assign SH_TDO = tdo_drv;

   bky_cfg_seq #(.CLKDIV(CLKDIV), .BITS_PER_AMP(48)) dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MASK(MASK), .VERIFY(VERIFY),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CNT(ERR_CNT), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
      .RD_DATA(RD_DATA), .SH_SEL(SH_SEL), .SH_F(SH_F), .SH_SHIFT(SH_SHIFT), .SH_CLK(SH_CLK),
      .SH_TDI(SH_TDI), .SH_TDO(SH_TDO), .MASK_OUT(MASK_OUT)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Returned bit for the next sample: oldest chain bit, optionally corrupted in pass 2.
   function automatic logic calc_tdo();
      logic b;
      int   k;
      b = chain[chain_len-1];
      k = edge_cnt - cur_nb;
      if (cur_verify && k >= 0 && k < cur_nb && fault_map[k]) b = ~b;
      return b;
   endfunction

   function automatic logic [28:0] outs();
      return {BUSY, DONE, ERR, ERR_CNT, RD_EN, RD_ADDR, SH_SEL, SH_F, SH_SHIFT, SH_CLK, SH_TDI, MASK_OUT};
   endfunction

   // Monitor: consumes expectations as the DUT presents reads, shift edges and DONE.
   always @(negedge CLK) begin : mon
      rec_t r;
      if (!RST) begin
         if (RD_EN) begin
            if (addr_q.size() == 0) fail_now("unexpected_read");
            else chk("rd_addr", RD_ADDR, addr_q.pop_front());
         end
         if (SH_CLK && !prev_clk) begin
            if (bit_q.size() == 0) fail_now("unexpected_shift_edge");
            else chk("sh_tdi", SH_TDI, bit_q.pop_front());
            chain = {chain[286:0], SH_TDI};
            edge_cnt++;
            tdo_drv = calc_tdo();
         end
         prev_clk = SH_CLK;
         if (DONE) begin
            if (done_q.size() == 0) fail_now("unexpected_done");
            else begin
               r = done_q.pop_front();
               chk("done_cycle", cyc, r.cyc);
               chk("err", ERR, r.err);
               chk("err_cnt", ERR_CNT, r.cnt);
               chk("edge_count", edge_cnt, r.edges);
            end
         end
         if (BUSY && MASK_OUT != exp_mask) inv_bad++;
         if (SH_SEL != BUSY || SH_F != BUSY) inv_bad++;
         if (SH_CLK && !SH_SHIFT) inv_bad++;
         if (SH_SHIFT && !BUSY) inv_bad++;
      end
   end

   task automatic flush();
      addr_q.delete();
      bit_q.delete();
      done_q.delete();
   endtask

   // Reference model: chain bit k is pattern word k/16, bit k%16; one read per word per pass.
   task automatic begin_seq(input logic [5:0] m, input logic v, input int nf, input int fixed_fault);
      int   n, nb, nw, passes, cnt;
      rec_t r;
      n = 0;
      for (int i = 0; i < 6; i++) n += int'(m[i]);
      if (m == 6'd0) n = 6;
      nb = 48 * n;
      nw = nb / 16;
      passes = v ? 2 : 1;
      for (int i = 0; i < 288; i++) fault_map[i] = 1'b0;
      if (fixed_fault >= 0) fault_map[fixed_fault] = 1'b1;
      for (int i = 0; i < nf; i++) fault_map[$urandom_range(0, nb - 1)] = 1'b1;
      cnt = 0;
      if (v) for (int i = 0; i < nb; i++) cnt += int'(fault_map[i]);
      cur_nb = nb;
      chain_len = nb;
      cur_verify = v;
      exp_mask = m;
      edge_cnt = 0;
      tdo_drv = calc_tdo();
      for (int p = 0; p < passes; p++) begin
         for (int k = 0; k < nb; k++) bit_q.push_back(mem[k / 16][k % 16]);
         for (int w = 0; w < nw; w++) addr_q.push_back(w);
      end
      r.cyc = cyc + 1 + passes * nw * (2 + 32 * CLKDIV);
      r.err = (cnt > 0) ? 1 : 0;
      r.cnt = (cnt > 511) ? 511 : cnt;
      r.edges = passes * nb;
      done_q.push_back(r);
      MASK = m;
      VERIFY = v;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      MASK = 6'($urandom);
      VERIFY = 1'($urandom);
   endtask

   task automatic wait_done();
      int lim;
      lim = (done_q.size() > 0) ? done_q[0].cyc - cyc + 20 : 20;
      for (int i = 0; i < lim && done_q.size() != 0; i++) @(negedge CLK);
      if (done_q.size() != 0) begin
         fail_now("done_timeout");
         flush();
      end
      chk("reads_left", addr_q.size(), 0);
      chk("bits_left", bit_q.size(), 0);
      chk("invariants", inv_bad, 0);
      inv_bad = 0;
   endtask

   task automatic new_pattern();
      for (int w = 0; w < 18; w++) mem[w] = 16'($urandom);
   endtask

   initial begin
      int mism;
      RST = 1'b1; START = 1'b0; ABORT = 1'b0; MASK = 6'd0; VERIFY = 1'b0;
      new_pattern();
      #1;
      chk("reset_outputs", int'(outs()), 0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // Single amplifier, no verify, word 0 = A5A5.
      mem[0] = 16'hA5A5;
      begin_seq(6'b000001, 1'b0, 0, -1);
      wait_done();
      mism = 0;
      for (int k = 0; k < 48; k++) if (chain[47 - k] != mem[k / 16][k % 16]) mism++;
      chk("chain_content", mism, 0);
      chk("chain_first_bit", chain[47], 1);

      // All six amplifiers, verify, clean loop-back.
      new_pattern();
      begin_seq(6'b000000, 1'b1, 0, -1);
      wait_done();

      // Same, with pass-2 bit 100 returned inverted.
      new_pattern();
      begin_seq(6'b000000, 1'b1, 0, 100);
      wait_done();

      // Two amplifiers, verify.
      new_pattern();
      begin_seq(6'b101000, 1'b1, 0, -1);
      wait_done();

      // ABORT and START together in IDLE: nothing starts.
      MASK = 6'b000001; START = 1'b1; ABORT = 1'b1;
      @(negedge CLK);
      START = 1'b0; ABORT = 1'b0;
      chk("abort_start_busy", BUSY, 0);
      repeat (5) @(negedge CLK);

      // ABORT 50 cycles into SHIFT, then a clean run.
      new_pattern();
      begin_seq(6'b010010, 1'b1, 0, -1);
      for (int i = 0; i < 20 && !SH_SHIFT; i++) @(negedge CLK);
      if (!SH_SHIFT) fail_now("shift_timeout");
      repeat (50) @(negedge CLK);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      chk("abort_busy", BUSY, 0);
      chk("abort_sh_clk", SH_CLK, 0);
      chk("abort_sh_shift", SH_SHIFT, 0);
      chk("abort_done", DONE, 0);
      flush();
      repeat (300) @(negedge CLK);
      chk("abort_invariants", inv_bad, 0);
      inv_bad = 0;
      new_pattern();
      begin_seq(6'b000110, 1'b1, 0, -1);
      wait_done();

      // Second START while BUSY must not disturb the running sequence.
      new_pattern();
      begin_seq(6'b000011, 1'b0, 0, -1);
      repeat (300) @(negedge CLK);
      MASK = 6'b111111; VERIFY = 1'b1; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_done();

      // Asynchronous reset while SH_CLK is high.
      new_pattern();
      begin_seq(6'b000000, 1'b0, 0, -1);
      for (int i = 0; i < 100 && !SH_CLK; i++) @(negedge CLK);
      if (!SH_CLK) fail_now("sh_clk_timeout");
      #2 RST = 1'b1;
      #1 chk("rst_mid_outputs", int'(outs()), 0);
      flush();
      @(negedge CLK);
      RST = 1'b0;
      prev_clk = 1'b0;
      inv_bad = 0;
      repeat (3) @(negedge CLK);
      new_pattern();
      begin_seq(6'b100001, 1'b1, 0, -1);
      wait_done();

      // Randomized masks, verify and injected faults.
      for (int s = 0; s < 4; s++) begin
         new_pattern();
         begin_seq(6'($urandom), 1'($urandom), $urandom_range(0, 3), -1);
         wait_done();
         repeat ($urandom_range(1, 5)) @(negedge CLK);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
